// File: rtl/oam_dma_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// oam_dma_controller : OAM DMA register and 160-byte copy engine between the
//                      CPU bus and the memory unit; transparent when idle.
// Revision 1.0
// ============================================================================
module oam_dma_controller #(
  parameter int unsigned  XFER_LEN     = 160,
  parameter logic [15:0]  OAM_BASE     = 16'hFE00,
  parameter logic [15:0]  DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_stall,
  output logic        dma_reg_hit,
  output logic [7:0]  dma_src,
  output logic        dma_active,
  output logic [15:0] mem_address,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] byte_buf_q, byte_buf_d;
  logic [7:0] dma_src_q, dma_src_d;
  logic [7:0] src_hi_q, src_hi_d;

  logic reg_sel;
  logic busy;

  assign reg_sel = (cpu_address == DMA_REG_ADDR);
  assign busy    = (state_q != IDLE);
  assign dma_src = dma_src_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_buf_d = byte_buf_q;
    dma_src_d  = dma_src_q;
    src_hi_d   = src_hi_q;
    case (state_q)
      IDLE: begin
        if (cpu_we && reg_sel) begin
          dma_src_d = cpu_wdata;
          // Echo-RAM pages E0-FF fold onto their work-RAM mirror C0-DF.
          src_hi_d  = (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;
          idx_d     = 8'h00;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = RD;
      RD: begin
        byte_buf_d = mem_rdata;
        state_d    = WR;
      end
      WR: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 8'h00;
      byte_buf_q <= 8'h00;
      dma_src_q  <= 8'h00;
      src_hi_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_buf_q <= byte_buf_d;
      dma_src_q  <= dma_src_d;
      src_hi_q   <= src_hi_d;
    end
  end

  // Gated by rst so the idle pass-through cannot leak CPU values while in reset.
  always_comb begin
    dma_active  = 1'b0;
    cpu_stall   = 1'b0;
    dma_reg_hit = 1'b0;
    mem_address = 16'h0000;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;
    if (rst) begin
      dma_active  = busy;
      cpu_stall   = busy & (cpu_re | cpu_we) & ~reg_sel;
      dma_reg_hit = cpu_re & reg_sel;
      case (state_q)
        IDLE: begin
          mem_address = cpu_address;
          mem_re      = cpu_re;
          mem_we      = cpu_we & ~reg_sel;
          mem_wdata   = cpu_wdata;
        end
        RD: begin
          mem_address = {src_hi_q, idx_q};
          mem_re      = 1'b1;
        end
        WR: begin
          mem_address = OAM_BASE + {8'h00, idx_q};
          mem_we      = 1'b1;
          mem_wdata   = byte_buf_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_oam_dma_controller : self-checking bench with a transfer-level model of
//                         the DMA engine and a 64 KiB memory unit.
// Revision 1.0
// ============================================================================
module tb_oam_dma_controller;

  localparam int          XFER_LEN = 160;
  localparam logic [15:0] OAM      = 16'hFE00;
  localparam logic [15:0] REG      = 16'hFF46;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_address;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_stall, dma_reg_hit, dma_active;
  logic [7:0]  dma_src;
  logic [15:0] mem_address;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  logic [1:0]  pre_op;
  logic [7:0]  pre_page, pre_seed;

  int n_cmp = 0;
  int n_bad = 0;

  oam_dma_controller dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .dma_reg_hit(dma_reg_hit), .dma_src(dma_src), .dma_active(dma_active),
    .mem_address(mem_address), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hash8(input logic [15:0] a, input logic [7:0] s);
    logic [15:0] x;
    x = (a * 16'h9E37) ^ {s, ~s};
    return x[15:8] ^ x[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory unit: combinational read, write on the clock edge, plus bulk preload.
  assign mem_rdata = mem[mem_address];
  always @(posedge clk) begin
    if (pre_op == 2'd1)
      for (int a = 0; a < 65536; a++) mem[a] <= hash8(16'(a), pre_seed);
    else if (pre_op == 2'd2)
      for (int i = 0; i < 256; i++) mem[{pre_page, 8'(i)}] <= 8'(i) ^ 8'h5A;
    if (mem_we) mem[mem_address] <= mem_wdata;
  end

  // Transfer-level model: m_t counts cycles since the start of a transfer;
  // cycle 0 is the start delay, then byte k is read at 2k+1 and written at 2k+2.
  bit         m_busy = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_src  = 8'h00;
  logic [7:0] m_page = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_src  <= 8'h00;
      m_page <= 8'h00;
    end else begin
      if (pre_op == 2'd1)
        for (int a = 0; a < 65536; a++) ref_mem[a] <= hash8(16'(a), pre_seed);
      else if (pre_op == 2'd2)
        for (int i = 0; i < 256; i++) ref_mem[{pre_page, 8'(i)}] <= 8'(i) ^ 8'h5A;
      if (!m_busy) begin
        if (cpu_we && cpu_address == REG) begin
          m_src  <= cpu_wdata;
          m_page <= (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
          m_busy <= 1'b1;
          m_t    <= 0;
        end else if (cpu_we) begin
          ref_mem[cpu_address] <= cpu_wdata;
        end
      end else begin
        if (m_t > 0 && m_t % 2 == 0)
          ref_mem[OAM + 16'((m_t - 2) / 2)] <= ref_mem[{m_page, 8'((m_t - 2) / 2)}];
        m_t <= m_t + 1;
        if (m_t == 2 * XFER_LEN) m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] ea;
    logic        ere, ewe, estall, ehit, eact;
    logic [7:0]  ewd, esrc;
    int          k;
    ea = 16'h0; ere = 1'b0; ewe = 1'b0; estall = 1'b0; ehit = 1'b0; eact = 1'b0;
    ewd = 8'h0; esrc = 8'h0; k = 0;
    if (rst) begin
      ehit = cpu_re && (cpu_address == REG);
      esrc = m_src;
      if (!m_busy) begin
        ea  = cpu_address;
        ere = cpu_re;
        ewe = cpu_we && (cpu_address != REG);
        ewd = cpu_wdata;
      end else begin
        eact   = 1'b1;
        estall = (cpu_re || cpu_we) && (cpu_address != REG);
        if (m_t % 2 == 1) begin
          k   = (m_t - 1) / 2;
          ea  = {m_page, 8'(k)};
          ere = 1'b1;
        end else if (m_t > 0) begin
          k   = (m_t - 2) / 2;
          ea  = OAM + 16'(k);
          ewe = 1'b1;
          ewd = ref_mem[{m_page, 8'(k)}];
        end
      end
    end
    chk("mem_address", 32'(mem_address), 32'(ea));
    chk("mem_re",      32'(mem_re),      32'(ere));
    chk("mem_we",      32'(mem_we),      32'(ewe));
    chk("mem_wdata",   32'(mem_wdata),   32'(ewd));
    chk("cpu_stall",   32'(cpu_stall),   32'(estall));
    chk("dma_reg_hit", 32'(dma_reg_hit), 32'(ehit));
    chk("dma_active",  32'(dma_active),  32'(eact));
    chk("dma_src",     32'(dma_src),     32'(esrc));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic re, input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_re = re; cpu_we = we; cpu_address = a; cpu_wdata = d;
  endtask

  task automatic preload(input logic [1:0] op, input logic [7:0] page, input logic [7:0] seed);
    pre_op = op; pre_page = page; pre_seed = seed;
    step();
    pre_op = 2'd0;
  endtask

  // Observes one transfer until the first idle cycle; bounded so it always returns.
  task automatic wait_idle(output int n_act, output int start_lat, output logic [15:0] first_rd,
                           output logic [15:0] last_wr, output int stall_bad);
    bit seen, got_rd, done;
    seen = 0; got_rd = 0; done = 0;
    n_act = 0; start_lat = -1; first_rd = 16'h0; last_wr = 16'h0; stall_bad = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (dma_active) begin
        if (!seen) start_lat = i;
        seen = 1;
        n_act++;
        if (mem_re && !got_rd) begin first_rd = mem_address; got_rd = 1; end
        if (mem_we) last_wr = mem_address;
        if ((cpu_re || cpu_we) && cpu_address != REG && !cpu_stall) stall_bad++;
      end else if (seen) begin
        done = 1;
      end
    end
    chk("xfer_finished", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_act, lat, stall_bad, errs, diffs;
    logic [15:0] first_rd, last_wr;
    logic [7:0]  snap [0:159];
    int r, op;
    logic [15:0] a;

    rst = 1'b0;
    pre_op = 2'd0; pre_page = 8'h0; pre_seed = 8'h0;
    bus(1'b1, 1'b1, 16'hFF40, 8'hA5);
    repeat (3) step();
    @(negedge clk);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_we",      32'(mem_we),      32'h0);
    step();
    rst = 1'b1;
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    preload(2'd1, 8'h00, 8'h3C);

    // Idle pass-through
    bus(1'b0, 1'b1, 16'hFF40, 8'h33);
    @(negedge clk);
    chk("idle_we",    32'(mem_we),      32'd1);
    chk("idle_addr",  32'(mem_address), 32'hFF40);
    chk("idle_wdata", 32'(mem_wdata),   32'h33);
    chk("idle_stall", 32'(cpu_stall),   32'd0);
    step();
    bus(1'b0, 1'b0, 16'h0000, 8'h00);

    // Basic copy from 0xC000 with a stalled CPU read during the transfer
    preload(2'd2, 8'hC0, 8'h00);
    bus(1'b0, 1'b1, REG, 8'hC0);
    @(negedge clk);
    chk("trig_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    bus(1'b1, 1'b0, 16'hC123, 8'h00);
    wait_idle(n_act, lat, first_rd, last_wr, stall_bad);
    chk("basic_start_lat", 32'(lat),       32'd0);
    chk("basic_active",    32'(n_act),     32'd321);
    chk("basic_first_rd",  32'(first_rd),  32'hC000);
    chk("basic_last_wr",   32'(last_wr),   32'hFE9F);
    chk("stall_every",     32'(stall_bad), 32'd0);
    chk("held_rd_re",      32'(mem_re),      32'd1);
    chk("held_rd_addr",    32'(mem_address), 32'hC123);
    chk("held_rd_stall",   32'(cpu_stall),   32'd0);
    step();
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    errs = 0;
    for (int i = 0; i < XFER_LEN; i++) if (mem[OAM + 16'(i)] !== (8'(i) ^ 8'h5A)) errs++;
    chk("basic_oam_errs", 32'(errs), 32'd0);

    // Register writes while active are discarded; reads are not stalled
    bus(1'b0, 1'b1, REG, 8'h80);
    step();
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (50) step();
    bus(1'b0, 1'b1, REG, 8'hC0);
    @(negedge clk);
    chk("reg_wr_stall", 32'(cpu_stall), 32'd0);
    step();
    bus(1'b1, 1'b0, REG, 8'h00);
    @(negedge clk);
    chk("reg_rd_hit",   32'(dma_reg_hit), 32'd1);
    chk("reg_rd_stall", 32'(cpu_stall),   32'd0);
    chk("reg_rd_src",   32'(dma_src),     32'h80);
    step();
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    wait_idle(n_act, lat, first_rd, last_wr, stall_bad);
    chk("reg_src_after", 32'(dma_src), 32'h80);
    step();
    errs = 0;
    for (int i = 0; i < XFER_LEN; i++) if (mem[OAM + 16'(i)] !== mem[16'h8000 + 16'(i)]) errs++;
    chk("reg_oam_errs", 32'(errs), 32'd0);

    // Echo page folds onto work RAM
    bus(1'b0, 1'b1, REG, 8'hE1);
    step();
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    wait_idle(n_act, lat, first_rd, last_wr, stall_bad);
    chk("echo_first_rd", 32'(first_rd), 32'hC100);
    chk("echo_last_wr",  32'(last_wr),  32'hFE9F);
    chk("echo_active",   32'(n_act),    32'd321);
    chk("echo_src",      32'(dma_src),  32'hE1);
    step();
    errs = 0;
    for (int i = 0; i < XFER_LEN; i++) if (mem[OAM + 16'(i)] !== mem[16'hC100 + 16'(i)]) errs++;
    chk("echo_oam_errs", 32'(errs), 32'd0);

    // Reset during transfer cycle 100: bytes 0..48 copied, the rest untouched
    for (int i = 0; i < XFER_LEN; i++) snap[i] = mem[OAM + 16'(i)];
    bus(1'b0, 1'b1, REG, 8'h90);
    step();
    bus(1'b1, 1'b0, REG, 8'h00);
    repeat (100) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_re",   32'(mem_re),      32'd0);
    chk("arst_mem_we",   32'(mem_we),      32'd0);
    chk("arst_addr",     32'(mem_address), 32'h0);
    chk("arst_wdata",    32'(mem_wdata),   32'h0);
    chk("arst_active",   32'(dma_active),  32'd0);
    chk("arst_stall",    32'(cpu_stall),   32'd0);
    chk("arst_hit",      32'(dma_reg_hit), 32'd0);
    chk("arst_src",      32'(dma_src),     32'h0);
    @(posedge clk); #1;
    step();
    rst = 1'b1;
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (20) step();
    errs = 0;
    for (int i = 0; i < XFER_LEN; i++) begin
      if (i < 49) begin
        if (mem[OAM + 16'(i)] !== mem[16'h9000 + 16'(i)]) errs++;
      end else if (mem[OAM + 16'(i)] !== snap[i]) errs++;
    end
    chk("arst_oam_errs", 32'(errs), 32'd0);

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 6000; c++) begin
      r  = int'($urandom_range(0, 15));
      op = int'($urandom_range(0, 3));
      if (r < 2)      a = REG;
      else if (r < 5) a = 16'hC123;
      else if (r < 7) a = OAM + 16'($urandom_range(0, 159));
      else            a = 16'($urandom);
      bus(op == 1, op == 2, a, 8'($urandom));
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (400) step();
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Implements the OAM DMA register (0xFF46) and the engine that copies 160 bytes from {src_hi, 8'h00} into OAM at 0xFE00–0xFE9F.
- Sits between the datapath's CPU bus (address, RE, WE, databus) and the memory unit.
- Owns the memory-unit port while a transfer runs and stalls the CPU for the duration.
- When idle it is a transparent pass-through.

Parameters:
- XFER_LEN, 160: bytes per transfer; index width is 8 bits, so the value must be ≤ 256.
- OAM_BASE, 16'hFE00: destination base address.
- DMA_REG_ADDR, 16'hFF46: CPU-visible trigger/source register address.

Ports:
- clk  input  1  CPU clock; all state on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_address  input  16  CPU bus address.
- cpu_re  input  1  CPU read strobe.
- cpu_we  input  1  CPU write strobe.
- cpu_wdata  input  8  CPU write data (databus when WE).
- cpu_stall  output  1  CPU must hold its current access and not advance.
- dma_reg_hit  output  1  CPU is reading DMA_REG_ADDR; the top-level bus mux drives dma_src.
- dma_src  output  8  last value written to DMA_REG_ADDR (readback).
- dma_active  output  1  transfer in progress.
- mem_address  output  16  address to memory unit.
- mem_re  output  1  read strobe to memory unit.
- mem_we  output  1  write strobe to memory unit.
- mem_wdata  output  8  write data to memory unit (valid when mem_we).
- mem_rdata  input  8  memory read data; combinationally valid in the same cycle as mem_re.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, idx=0, byte_buf=0, dma_src=0.
  - Outputs: dma_active=0, cpu_stall=0, dma_reg_hit=0, mem_re=0, mem_we=0, mem_address=0, mem_wdata=0.
  - Reset mid-transfer aborts immediately; OAM keeps whatever bytes were already written.
- States: IDLE, SETUP, RD, WR.
- IDLE:
  - mem_address=cpu_address, mem_re=cpu_re, mem_wdata=cpu_wdata.
  - mem_we=cpu_we & (cpu_address!=DMA_REG_ADDR).
  - dma_reg_hit=cpu_re & (cpu_address==DMA_REG_ADDR).
  - If cpu_we & cpu_address==DMA_REG_ADDR: dma_src<=cpu_wdata, src_hi<=(cpu_wdata>=8'hE0 ? cpu_wdata & 8'hDF : cpu_wdata), idx<=0, go to SETUP.
- SETUP (1 cycle):
  - dma_active=1, mem strobes 0, go to RD.
  - This is the start delay: the triggering write completes in IDLE and the first bus cycle is taken the cycle after.
- RD:
  - mem_address={src_hi, idx}, mem_re=1, mem_we=0.
  - byte_buf<=mem_rdata; go to WR.
- WR:
  - mem_address=OAM_BASE+{8'h00, idx}, mem_we=1, mem_wdata=byte_buf.
  - If idx==XFER_LEN-1: go to IDLE, idx<=0. Else idx<=idx+1, go to RD.
- Timing: dma_active=1 in SETUP/RD/WR, so busy for 1+2*XFER_LEN = 321 cycles. dma_active falls in the cycle after the final WR.
- cpu_stall=dma_active & (cpu_re|cpu_we) & (cpu_address!=DMA_REG_ADDR). The CPU's stalled access is not forwarded; it completes in the first IDLE cycle.
- Register access while active:
  - Writes to DMA_REG_ADDR are not stalled and are discarded: no restart, dma_src and src_hi unchanged.
  - Reads of DMA_REG_ADDR are not stalled; dma_reg_hit=1.
- No CPU bus accesses reach memory while active (no HRAM exception in this revision).
- Index/address arithmetic: idx is 8-bit; the source low byte is idx directly, with no carry into src_hi.
- Simultaneous events: a trigger write in the same cycle as the final WR is seen in IDLE only after the return. The CPU is not stalled on that write and the write is discarded, because state is WR in that cycle.

Test Plan:
- Basic copy: preload 0xC000–0xC09F with i^8'h5A; write 0xC0 to 0xFF46.
  - OAM 0xFE00+i == i^8'h5A for all i<160.
  - dma_active high for exactly 321 cycles, starting the cycle after the write.
  - First mem_re address 0xC000; last mem_we address 0xFE9F.
- CPU stall: during the transfer, the CPU reads 0xC123.
  - cpu_stall=1 every cycle until dma_active falls.
  - The read is issued on the memory port in the first IDLE cycle with mem_address=0xC123.
- Register behaviour: write 0x80 to 0xFF46, then write 0xC0 at cycle 50 of the transfer, then read 0xFF46.
  - dma_src stays 0x80 and all 160 bytes come from 0x8000 page.
  - The read gives dma_reg_hit=1, cpu_stall=0.
- Echo mapping: write 0xE1.
  - Source reads hit 0xC100–0xC19F; dma_src reads back 0xE1.
- Reset mid-transfer: assert rst low at cycle 100.
  - All outputs are 0 immediately (async).
  - OAM bytes 0–48 updated, byte 49 onward unchanged; no further mem strobes after release.
- Idle pass-through: CPU write 0x33 to 0xFF40 when idle.
  - mem_we=1, mem_address=0xFF40, mem_wdata=0x33 same cycle, cpu_stall=0.
  - A write to 0xFF46 produces mem_we=0.
